// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite slave in front of a word-addressed memory; out-of-window accesses complete with SLVERR.
// Latency: BVALID one edge after the later of AW/W, RVALID one edge after AR; all outputs registered.
// Backpressure: B and R are held until BREADY/RREADY; no new AW/W/AR is accepted while a response is pending.
module axi4lite_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_WORDS  = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [63:0]           SPAN64 = 64'(NUM_WORDS) << 2;
    localparam logic [ADDR_WIDTH:0]   SPAN   = SPAN64[ADDR_WIDTH:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // One extra bit keeps the offset from wrapping, so addresses below BASE fall out of range.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

    // ---------------- write path ----------------
    wstate_t               r_wstate, w_wstate_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_wready, w_wready_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;

    logic                  w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_commit, w_wr_ok;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx;

    assign w_aw_hs   = AWVALID & r_awready;
    assign w_w_hs    = WVALID & r_wready;
    // In W_WAIT a dropped READY means that channel's beat is already latched.
    assign w_have_aw = w_aw_hs | ((r_wstate == W_WAIT) & ~r_awready);
    assign w_have_w  = w_w_hs  | ((r_wstate == W_WAIT) & ~r_wready);
    assign w_wr_addr = w_aw_hs ? AWADDR : r_awaddr;
    assign w_wr_data = w_w_hs  ? WDATA  : r_wdata;
    assign w_wr_strb = w_w_hs  ? WSTRB  : r_wstrb;
    assign w_wr_ok   = in_range(w_wr_addr);
    assign w_wr_idx  = to_idx(w_wr_addr);

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_commit      = 1'b0;
        case (r_wstate)
            W_IDLE, W_WAIT: begin
                if (w_have_aw && w_have_w) begin
                    w_commit      = 1'b1;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_bresp_nxt   = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                    w_wstate_nxt  = W_RESP;
                end else if (w_have_aw) begin
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b1;
                    w_wstate_nxt  = W_WAIT;
                end else if (w_have_w) begin
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b0;
                    w_wstate_nxt  = W_WAIT;
                end else begin
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            if (w_aw_hs) r_awaddr <= AWADDR;
            if (w_w_hs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_commit && w_wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]            r_rresp, w_rresp_nxt;
    logic                  w_ar_hs, w_rd_ok;
    logic [IDX_W-1:0]      w_rd_idx;

    assign w_ar_hs  = ARVALID & r_arready;
    assign w_rd_ok  = in_range(ARADDR);
    assign w_rd_idx = to_idx(ARADDR);

    // r_mem is sampled before this edge's write lands, so a same-edge read sees old data.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_rdata_nxt   = w_rd_ok ? r_mem[w_rd_idx] : '0;
                    w_rresp_nxt   = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                    w_rstate_nxt  = R_DATA;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_rstate_nxt  = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

endmodule
